ode_burst_ram: RTL



---
 rtl/ode_mem_pkg.sv | 15 +
 rtl/ode_read_pipe.sv | 71 +++++++
 rtl/ode_burst_ram.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ode_mem_pkg.sv
// Shared types for the ODE solver scratch memory: controller states and
// the legal range of the read pipeline depth.
package ode_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

endpackage

// File: rtl/ode_read_pipe.sv
// Read data pipeline: READ_LAT stages of {valid, last, data}. Data in a stage
// only moves when a valid beat moves, so the output word holds between beats.
module ode_read_pipe #(
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [DATA_W-1:0] out_data,
    output logic              non_empty,
    output logic              pending
);

    logic [READ_LAT-1:0] v_q;
    logic [READ_LAT-1:0] l_q;
    logic [DATA_W-1:0]   d_q   [READ_LAT];
    logic [READ_LAT-1:0] src_v;
    logic [READ_LAT-1:0] src_l;
    logic [DATA_W-1:0]   src_d [READ_LAT];

    always_comb begin
        src_v    = '0;
        src_l    = '0;
        src_v[0] = in_valid;
        src_l[0] = in_last;
        src_d[0] = in_data;
        for (int i = 1; i < READ_LAT; i++) begin
            src_v[i] = v_q[i-1];
            src_l[i] = l_q[i-1];
            src_d[i] = d_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            l_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q <= src_v;
            l_q <= src_v & src_l;
            for (int i = 0; i < READ_LAT; i++) begin
                if (src_v[i]) begin
                    d_q[i] <= src_d[i];
                end
            end
        end
    end

    // pending ignores the output stage: once only that stage is valid the
    // pipeline is empty on the following cycle.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < READ_LAT - 1; i++) begin
            pending = pending | v_q[i];
        end
    end

    assign non_empty = |v_q;
    assign out_valid = v_q[READ_LAT-1];
    assign out_last  = l_q[READ_LAT-1];
    assign out_data  = d_q[READ_LAT-1];

endmodule

// File: rtl/ode_burst_ram.sv
// Single-port burst scratch memory for the ODE solver: write and read bursts
// with address auto-increment and wrap, and a READ_LAT-stage read pipeline.
module ode_burst_ram
    import ode_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 64,
    parameter int BLEN_W   = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BLEN_W-1:0] req_len,
    input  logic              wdata_valid,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ready,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output state_t            state_dbg
);

    // Handshakes: a request transfers on a cycle with req_valid && req_ready,
    // a write beat on wdata_valid && wdata_ready; read beats carry no ready and
    // are delivered on consecutive cycles while rdata_valid is high.

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_lat_check
        $error("ode_burst_ram: READ_LAT must be within 1..4");
    end

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [BLEN_W:0]   COUNT_ONE = (BLEN_W + 1)'(1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BLEN_W:0]   count_q;
    logic              req_ready_q;
    logic              wdata_ready_q;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              wr_en;
    logic              issue;
    logic              issue_last;
    logic              pipe_non_empty;
    logic              pipe_pending;

    assign wr_en      = !reset && (state_q == WRITE) && wdata_valid;
    assign issue      = (state_q == READ);
    assign issue_last = (count_q == COUNT_ONE);

    // Memory contents survive reset; only the controller is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            req_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        count_q     <= (BLEN_W + 1)'(req_len) + COUNT_ONE;
                        req_ready_q <= 1'b0;
                        if (req_wr) begin
                            state_q       <= WRITE;
                            wdata_ready_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (wdata_valid) begin
                        addr_q  <= addr_q + ADDR_ONE;
                        count_q <= count_q - COUNT_ONE;
                        if (count_q == COUNT_ONE) begin
                            state_q       <= IDLE;
                            wdata_ready_q <= 1'b0;
                            req_ready_q   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    addr_q  <= addr_q + ADDR_ONE;
                    count_q <= count_q - COUNT_ONE;
                    if (count_q == COUNT_ONE) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave as the final beat reaches rdata so req_ready
                    // rises the cycle after rdata_last.
                    if (!pipe_pending) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    req_ready_q   <= 1'b1;
                    wdata_ready_q <= 1'b0;
                end
            endcase
        end
    end

    ode_read_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_read_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue),
        .in_last   (issue_last),
        .in_data   (mem[addr_q]),
        .out_valid (rdata_valid),
        .out_last  (rdata_last),
        .out_data  (rdata),
        .non_empty (pipe_non_empty),
        .pending   (pipe_pending)
    );

    assign req_ready   = req_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign busy        = (state_q != IDLE) || pipe_non_empty;
    assign state_dbg   = state_q;

endmodule
